// File: rtl/output_deskew.sv
// Output-edge deskew for the systolic array: re-aligns the k-cycle staggered lanes into one
// valid vector, frames the aligned beats and flags words that arrive with only some lanes valid.
module output_deskew #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 16,
    localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LANES*DATA_WIDTH-1:0] i_data,
    input  logic [LANES-1:0]            i_valid,
    input  logic                        i_clr_err,
    output logic [LANES*DATA_WIDTH-1:0] o_data,
    output logic                        o_valid,
    output logic                        o_last,
    output logic [CNT_W-1:0]            o_beat_cnt,
    output logic                        o_err
);

    // Handshake: o_valid is a one-cycle strobe per aligned word with no ready; the consumer
    // must take every beat presented, since the array upstream cannot be stalled.

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [LANES*DATA_WIDTH-1:0] av;
    logic [LANES-1:0]            vv;
    logic [CNT_W-1:0]            cnt;
    logic                        all_valid;
    logic                        mixed_valid;

    // Lane k needs LANES-1-k stages so every lane of a word lines up with the last lane.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int D = LANES - 1 - k;
        if (D == 0) begin : g_pass
            assign av[k*DATA_WIDTH +: DATA_WIDTH] = i_data[k*DATA_WIDTH +: DATA_WIDTH];
            assign vv[k]                          = i_valid[k];
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] d_sr [D];
            logic                  v_sr [D];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        d_sr[i] <= '0;
                        v_sr[i] <= 1'b0;
                    end
                end else begin
                    d_sr[0] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
                    v_sr[0] <= i_valid[k];
                    for (int i = 1; i < D; i++) begin
                        d_sr[i] <= d_sr[i-1];
                        v_sr[i] <= v_sr[i-1];
                    end
                end
            end

            assign av[k*DATA_WIDTH +: DATA_WIDTH] = d_sr[D-1];
            assign vv[k]                          = v_sr[D-1];
        end
    end

    assign all_valid   = &vv;
    assign mixed_valid = (|vv) && !all_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_beat_cnt <= '0;
            o_err      <= 1'b0;
            cnt        <= '0;
        end else begin
            if (all_valid) begin
                o_valid    <= 1'b1;
                o_data     <= av;
                o_beat_cnt <= cnt;
                o_last     <= (cnt == CNT_LAST);
                cnt        <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end else begin
                // Idle or dropped word: data and beat index hold for the consumer.
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end

            // A dropped word in the same cycle as a clear keeps the error visible.
            if (mixed_valid) begin
                o_err <= 1'b1;
            end else if (i_clr_err) begin
                o_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_output_deskew.sv
// Directed bench for output_deskew: skews words onto the lanes, queues expected aligned beats
// with their arrival cycle, and a negedge monitor checks every o_valid against that queue.
module tb_output_deskew;

    localparam int L     = 4;
    localparam int DW    = 8;
    localparam int FL    = 4;
    localparam int CW    = 2;
    localparam int EXP_W = 16 + 1 + CW + L*DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [L*DW-1:0] i_data;
    logic [L-1:0]    i_valid;
    logic            i_clr_err;
    logic [L*DW-1:0] o_data;
    logic            o_valid;
    logic            o_last;
    logic [CW-1:0]   o_beat_cnt;
    logic            o_err;

    output_deskew #(.LANES(L), .DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .i_clr_err  (i_clr_err),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_last     (o_last),
        .o_beat_cnt (o_beat_cnt),
        .o_err      (o_err)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state: {arrival cycle, last, beat, data}
    logic [EXP_W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Lane history: hd[k]/hm[k] is the word issued k cycles ago.
    logic [L*DW-1:0] hd [L];
    logic [L-1:0]    hm [L];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_lanes();
        for (int k = 0; k < L; k++) begin
            hd[k] = '0;
            hm[k] = '0;
        end
        i_data    = '0;
        i_valid   = '0;
        i_clr_err = 1'b0;
    endtask

    // Driver: issue one logical word (lane 0 now, lane k k cycles later) and advance a cycle.
    task automatic step(input logic [L*DW-1:0] d, input logic [L-1:0] m, input logic clr,
                        input logic push, input logic [CW-1:0] beat, input logic last);
        for (int k = L-1; k > 0; k--) begin
            hd[k] = hd[k-1];
            hm[k] = hm[k-1];
        end
        hd[0] = d;
        hm[0] = m;
        for (int k = 0; k < L; k++) begin
            i_data[k*DW +: DW] = hd[k][k*DW +: DW];
            i_valid[k]         = hm[k][k];
        end
        i_clr_err = clr;
        if (push) exp_q.push_back({16'(cyc + L), last, beat, d});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        clear_lanes();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: every o_valid must match the queue head at exactly its expected cycle.
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        while (exp_q.size() > 0 && int'(exp_q[0][EXP_W-1 -: 16]) < cyc) begin
            e = exp_q.pop_front();
            check("beat_missing", 64'(0), 64'(1));
        end
        if (o_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("valid_unexpected", 64'(o_valid), 64'(0));
            end else if (int'(exp_q[0][EXP_W-1 -: 16]) != cyc) begin
                check("valid_early", 64'(cyc), 64'(exp_q[0][EXP_W-1 -: 16]));
            end else begin
                e = exp_q.pop_front();
                check("o_data", 64'(o_data), 64'(e[L*DW-1:0]));
                check("o_beat_cnt", 64'(o_beat_cnt), 64'(e[L*DW +: CW]));
                check("o_last", 64'(o_last), 64'(e[L*DW+CW]));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear_lanes();

        // 1: reset with random lane activity
        for (int i = 0; i < 3; i++) begin
            i_data  = $urandom;
            i_valid = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        check("rst_o_data", 64'(o_data), 64'(0));
        check("rst_o_valid", 64'(o_valid), 64'(0));
        check("rst_o_last", 64'(o_last), 64'(0));
        check("rst_o_beat_cnt", 64'(o_beat_cnt), 64'(0));
        check("rst_o_err", 64'(o_err), 64'(0));
        clear_lanes();
        rst_n = 1'b1;

        // 2: single word
        step(32'h13121110, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0);
        idle(5);
        check("one_word_err", 64'(o_err), 64'(0));

        // 3: six back-to-back words, frame wrap
        do_reset(1);
        for (int i = 0; i < 6; i++)
            step({8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i), 8'(i)}, 4'hF, 1'b0, 1'b1,
                 2'(i % FL), (i % FL) == FL - 1);
        idle(5);

        // 4: dropped word sets sticky error, beat index does not advance
        do_reset(1);
        step(32'h44434241, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0);
        step(32'h55545352, 4'b1011, 1'b0, 1'b0, 2'd0, 1'b0);
        step(32'h66656463, 4'hF, 1'b0, 1'b1, 2'd1, 1'b0);
        idle(3);
        check("err_set", 64'(o_err), 64'(1));
        step('0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("err_clr", 64'(o_err), 64'(0));
        idle(1);
        check("err_clr_hold", 64'(o_err), 64'(0));
        // clear lands on the same edge as the dropped word reaching the output
        step(32'h77767574, 4'b1011, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(2);
        step('0, '0, 1'b1, 1'b0, '0, 1'b0);
        check("err_wins_clr", 64'(o_err), 64'(1));
        idle(1);
        check("err_sticky", 64'(o_err), 64'(1));
        step(32'h88878685, 4'hF, 1'b0, 1'b1, 2'd2, 1'b0);
        idle(5);

        // 5: output holds through idle cycles
        do_reset(1);
        step(32'hA3A2A1A0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0);
        idle(3);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("hold_o_data", 64'(o_data), 64'(32'hA3A2A1A0));
            check("hold_o_valid", 64'(o_valid), 64'(0));
        end

        // 6: reset pulse with two words still in flight
        do_reset(1);
        step(32'hB3B2B1B0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0);
        step(32'hC3C2C1C0, 4'hF, 1'b0, 1'b1, 2'd1, 1'b0);
        step(32'hD3D2D1D0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
        step(32'hE3E2E1E0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(1);
        do_reset(1);
        for (int i = 0; i < 4; i++)
            step({8'(8'hF3 + i), 8'(8'hE2 + i), 8'(8'hD1 + i), 8'(8'hC0 + i)}, 4'hF, 1'b0, 1'b1,
                 2'(i), i == 3);
        idle(6);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
